prog_load_imem: RTL

- Parametrised instruction memory for the single-cycle CPU family; replaces bench-side forcing of program words with an in-design load port.
- After reset, clears the whole array to a fill word, one word per cycle.
- Then accepts a program burst over a valid/ready stream while holding the CPU.
- Serves combinational fetch reads at `pc` to the datapath.

---
 rtl/prog_load_imem.sv | 122 ++++++++++++
 1 files changed

// File: rtl/prog_load_imem.sv
// Instruction memory for the single-cycle CPU: clears itself after reset, accepts a
// program burst over a valid/ready stream while holding the CPU, then serves fetches.
module prog_load_imem #(
  parameter int                 DATA_W    = 16,
  parameter int                 ADDR_W    = 8,
  parameter logic [DATA_W-1:0]  FILL_WORD = '0
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic [ADDR_W-1:0] pc,
  output logic [DATA_W-1:0] instr,
  output logic              cpu_hold,
  input  logic              ld_start,
  input  logic [ADDR_W-1:0] ld_base,
  input  logic [ADDR_W:0]   ld_len,
  input  logic              ld_valid,
  input  logic [DATA_W-1:0] ld_data,
  output logic              ld_ready,
  output logic              load_done,
  output logic [ADDR_W:0]   ld_count,
  output logic [DATA_W-1:0] checksum
);

  localparam int             DEPTH   = 2 ** ADDR_W;
  localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W + 1)'(DEPTH);
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

  localparam logic [1:0] S_CLEAR = 2'd0;
  localparam logic [1:0] S_IDLE  = 2'd1;
  localparam logic [1:0] S_LOAD  = 2'd2;

  logic [1:0]        r_state;
  logic [ADDR_W-1:0] r_clr_ptr;
  logic [ADDR_W-1:0] r_wr_ptr;
  logic [ADDR_W:0]   r_rem;
  logic [ADDR_W:0]   r_ld_count;
  logic [DATA_W-1:0] r_checksum;
  logic              r_load_done;
  logic [DATA_W-1:0] r_mem [DEPTH];

  logic              w_we;
  logic [ADDR_W-1:0] w_waddr;
  logic [DATA_W-1:0] w_wdata;
  logic [ADDR_W:0]   w_len_sat;

  assign w_len_sat = (ld_len > DEPTH_L) ? DEPTH_L : ld_len;

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state     <= S_CLEAR;
      r_clr_ptr   <= '0;
      r_wr_ptr    <= '0;
      r_rem       <= '0;
      r_ld_count  <= '0;
      r_checksum  <= '0;
      r_load_done <= 1'b0;
    end else begin
      r_load_done <= 1'b0;
      case (r_state)
        S_CLEAR: begin
          r_clr_ptr <= r_clr_ptr + 1'b1;
          if (r_clr_ptr == LAST_ADDR) r_state <= S_IDLE;
        end
        S_IDLE: begin
          if (ld_start) begin
            r_ld_count <= '0;
            r_checksum <= '0;
            if (ld_len != '0) begin
              r_wr_ptr <= ld_base;
              r_rem    <= w_len_sat;
              r_state  <= S_LOAD;
            end else begin
              // An empty burst still completes, so software sees a done pulse.
              r_load_done <= 1'b1;
            end
          end
        end
        S_LOAD: begin
          if (ld_valid) begin
            r_wr_ptr   <= r_wr_ptr + 1'b1;
            r_rem      <= r_rem - 1'b1;
            r_ld_count <= r_ld_count + 1'b1;
            r_checksum <= r_checksum + ld_data;
            if (r_rem == (ADDR_W + 1)'(1)) begin
              r_state     <= S_IDLE;
              r_load_done <= 1'b1;
            end
          end
        end
        default: r_state <= S_CLEAR;
      endcase
    end
  end

  // Single write port shared by the clear sweep and the load stream.
  always_comb begin
    w_we    = 1'b0;
    w_waddr = r_clr_ptr;
    w_wdata = FILL_WORD;
    if (!RST) begin
      if (r_state == S_CLEAR) begin
        w_we = 1'b1;
      end else if (r_state == S_LOAD && ld_valid) begin
        w_we    = 1'b1;
        w_waddr = r_wr_ptr;
        w_wdata = ld_data;
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (w_we) r_mem[w_waddr] <= w_wdata;
  end

  assign cpu_hold  = (r_state != S_IDLE);
  assign ld_ready  = (r_state == S_LOAD);
  assign load_done = r_load_done;
  assign ld_count  = r_ld_count;
  assign checksum  = r_checksum;
  assign instr     = cpu_hold ? FILL_WORD : r_mem[pc];

endmodule
